// File: rtl/state_sequencer_pkg.sv
// rtl/state_sequencer_pkg.sv - shared sizes, state constants and request encoding for state_sequencer
package state_sequencer_pkg;

    localparam int STATE_W_DEF     = 8;
    localparam int LAST_STATE_DEF  = 255;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int DWELL_W_DEF     = 4;

    localparam int ST_FIRST = 0;

    typedef enum logic [2:0] {
        REQ_NONE = 3'd0,
        REQ_NEXT = 3'd1,
        REQ_JUMP = 3'd2,
        REQ_CALL = 3'd3,
        REQ_RET  = 3'd4
    } req_e;

    // Control flow outranks sequential advance; hold is handled by the caller.
    function automatic req_e encode_req(input logic next_req, input logic jump_req,
                                        input logic call_req, input logic ret_req);
        if (ret_req)       return REQ_RET;
        else if (call_req) return REQ_CALL;
        else if (jump_req) return REQ_JUMP;
        else if (next_req) return REQ_NEXT;
        else               return REQ_NONE;
    endfunction

endpackage

// File: rtl/state_sequencer_if.sv
// rtl/state_sequencer_if.sv - request/status bundle between decode and the state sequencer
interface state_sequencer_if
    import state_sequencer_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int SP_W    = $clog2(STACK_DEPTH_DEF + 1)
);
    logic               next_state;
    logic               hold;
    logic               jump;
    logic               call;
    logic               ret;
    logic [STATE_W-1:0] target;
    logic [DWELL_W-1:0] dwell;
    logic [STATE_W-1:0] state;
    logic               state_enter;
    logic               at_last;
    logic               done;
    logic               busy;
    logic               stack_err;
    logic [SP_W-1:0]    sp;

    modport master (
        output next_state, hold, jump, call, ret, target, dwell,
        input  state, state_enter, at_last, done, busy, stack_err, sp
    );

    modport slave (
        input  next_state, hold, jump, call, ret, target, dwell,
        output state, state_enter, at_last, done, busy, stack_err, sp
    );
endinterface

// File: rtl/state_sequencer_stack.sv
// rtl/state_sequencer_stack.sv - LIFO return stack for call/ret, updated on negedge clk
module seq_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [SP_W-1:0]  sp
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = AW'(sp_q);
    assign rd_idx = AW'(sp_q - SP_W'(1));
    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);
    assign dout   = mem[rd_idx];
    assign sp     = sp_q;

    always_ff @(negedge clk) begin
        if (!rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            sp_q        <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end
endmodule

// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - phase/state sequencer with jump, call/return, hold, min-dwell and wrap/stop
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int STATE_W     = STATE_W_DEF,
    parameter int LAST_STATE  = LAST_STATE_DEF,
    parameter bit WRAP_EN     = 1'b1,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int DWELL_W     = DWELL_W_DEF
) (
    input logic               clk,
    input logic               rst,
    state_sequencer_if.slave  bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [STATE_W-1:0] LAST = STATE_W'(LAST_STATE);

    logic [STATE_W-1:0] state_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               enter_q;
    logic               done_q;
    logic               err_q;

    logic [STATE_W-1:0] succ;
    logic [STATE_W-1:0] tgt_clamped;
    logic [STATE_W-1:0] stack_top;
    logic [STATE_W-1:0] next_val;
    logic [SP_W-1:0]    sp;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               load;
    logic               set_done;
    logic               set_err;
    req_e               req;

    assign req         = encode_req(bus.next_state, bus.jump, bus.call, bus.ret);
    assign succ        = (state_q == LAST) ? (WRAP_EN ? '0 : LAST) : state_q + STATE_W'(1);
    assign tgt_clamped = (bus.target > LAST) ? LAST : bus.target;

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        load     = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        next_val = state_q;
        if (rst && !bus.hold) begin
            case (req)
                REQ_RET: begin
                    if (empty) set_err = 1'b1;
                    else begin
                        pop      = 1'b1;
                        load     = 1'b1;
                        next_val = stack_top;
                    end
                end
                REQ_CALL: begin
                    if (full) set_err = 1'b1;
                    else begin
                        push     = 1'b1;
                        load     = 1'b1;
                        next_val = tgt_clamped;
                    end
                end
                REQ_JUMP: begin
                    load     = 1'b1;
                    next_val = tgt_clamped;
                end
                REQ_NEXT: begin
                    // Stopping at the last state is not a state change: no enter pulse, no dwell reload.
                    if (cnt_q == '0) begin
                        if (state_q != LAST || WRAP_EN) begin
                            load     = 1'b1;
                            next_val = succ;
                        end else begin
                            set_done = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    seq_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (STATE_W),
        .SP_W  (SP_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (succ),
        .dout  (stack_top),
        .full  (full),
        .empty (empty),
        .sp    (sp)
    );

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q <= STATE_W'(ST_FIRST);
            cnt_q   <= '0;
            enter_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.hold) begin
            enter_q <= 1'b0;
        end else begin
            if (load) begin
                state_q <= next_val;
                cnt_q   <= bus.dwell;
                enter_q <= 1'b1;
            end else begin
                cnt_q   <= (cnt_q != '0) ? cnt_q - DWELL_W'(1) : cnt_q;
                enter_q <= 1'b0;
            end
            done_q <= done_q | set_done;
            err_q  <= err_q | set_err;
        end
    end

    assign bus.state       = state_q;
    assign bus.state_enter = enter_q;
    assign bus.at_last     = (state_q == LAST);
    assign bus.done        = done_q;
    assign bus.busy        = (cnt_q != '0);
    assign bus.stack_err   = err_q;
    assign bus.sp          = sp;
endmodule
